// File: rtl/dcache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : dcache_ctrl_pkg
// Brief   : Address field geometry and FSM state encoding for dcache_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
package dcache_ctrl_pkg;

    localparam int TAG_W   = 8;
    localparam int IDX_W   = 5;
    localparam int WPL     = 4;
    localparam int OFF_W   = 2;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int NLINES  = 1 << IDX_W;

    localparam int OFF_LSB = 1;
    localparam int IDX_LSB = OFF_LSB + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVICT = 2'd1,
        ST_FILL  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [TAG_W-1:0] tag,
        input logic [IDX_W-1:0] idx,
        input logic [OFF_W-1:0] off
    );
        return {tag, idx, off, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_ctrl_cache_array.sv
`default_nettype none
// ============================================================================
// Module : cache_array
// Brief  : Tag/valid/dirty and data storage, combinational read, clocked write.
// Rev    : 1.0  initial release
// ============================================================================
module cache_array
    import dcache_ctrl_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IDX_W-1:0]             rd_idx,
    output logic                         rd_valid,
    output logic                         rd_dirty,
    output logic [TAG_W-1:0]             rd_tag,
    output logic [WPL-1:0][DATA_W-1:0]   rd_line,
    input  logic                         meta_we,
    input  logic [IDX_W-1:0]             meta_idx,
    input  logic                         meta_dirty,
    input  logic [TAG_W-1:0]             meta_tag,
    input  logic                         data_we,
    input  logic [IDX_W-1:0]             data_idx,
    input  logic [OFF_W-1:0]             data_off,
    input  logic [DATA_W-1:0]            data_wdata
);

    logic [NLINES-1:0]               r_valid;
    logic [NLINES-1:0]               r_dirty;
    logic [TAG_W-1:0]                r_tag  [NLINES];
    logic [WPL-1:0][DATA_W-1:0]      r_data [NLINES];

    assign rd_valid = r_valid[rd_idx];
    assign rd_dirty = r_dirty[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_line  = r_data[rd_idx];

    // Only the status bits need reset; tags and data are qualified by valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (meta_we) begin
            r_valid[meta_idx] <= 1'b1;
            r_dirty[meta_idx] <= meta_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (meta_we) begin
            r_tag[meta_idx] <= meta_tag;
        end
        if (data_we) begin
            r_data[data_idx][data_off] <= data_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dcache_ctrl
// Brief  : Direct-mapped write-back/write-allocate data cache controller.
// Rev    : 1.0  initial release
// ============================================================================
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                stall,
    output logic                done,
    output logic [DATA_W-1:0]   rdata,
    output logic                hit,
    output logic                err,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [OFF_W-1:0] c_LAST_OFF = OFF_W'(WPL - 1);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [ADDR_W-1:OFF_LSB]     r_req_addr;
    logic                        r_req_write;
    logic [DATA_W-1:0]           r_req_wdata;
    logic [OFF_W-1:0]            r_iss_cnt;
    logic [OFF_W-1:0]            r_ret_cnt;
    logic                        r_iss_done;

    logic                        w_latch;
    logic                        w_iss_adv;
    logic                        w_ret_adv;
    logic [IDX_W-1:0]            w_in_idx, w_lt_idx, w_rd_idx;
    logic [TAG_W-1:0]            w_in_tag, w_lt_tag;
    logic [OFF_W-1:0]            w_in_off, w_lt_off;
    logic                        w_hit;

    logic                        w_rd_valid, w_rd_dirty;
    logic [TAG_W-1:0]            w_rd_tag;
    logic [WPL-1:0][DATA_W-1:0]  w_rd_line;
    logic                        w_meta_we, w_meta_dirty;
    logic [TAG_W-1:0]            w_meta_tag;
    logic                        w_data_we;
    logic [IDX_W-1:0]            w_data_idx;
    logic [OFF_W-1:0]            w_data_off;
    logic [DATA_W-1:0]           w_data_wdata;

    assign w_in_idx = req_addr[IDX_LSB +: IDX_W];
    assign w_in_tag = req_addr[TAG_LSB +: TAG_W];
    assign w_in_off = req_addr[OFF_LSB +: OFF_W];
    assign w_lt_idx = r_req_addr[IDX_LSB +: IDX_W];
    assign w_lt_tag = r_req_addr[TAG_LSB +: TAG_W];
    assign w_lt_off = r_req_addr[OFF_LSB +: OFF_W];

    // Outside IDLE the array is addressed by the latched request only.
    assign w_rd_idx = (r_state == ST_IDLE) ? w_in_idx : w_lt_idx;
    assign w_hit    = w_rd_valid && (w_rd_tag == w_in_tag);

    cache_array u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (w_rd_idx),
        .rd_valid   (w_rd_valid),
        .rd_dirty   (w_rd_dirty),
        .rd_tag     (w_rd_tag),
        .rd_line    (w_rd_line),
        .meta_we    (w_meta_we),
        .meta_idx   (w_rd_idx),
        .meta_dirty (w_meta_dirty),
        .meta_tag   (w_meta_tag),
        .data_we    (w_data_we),
        .data_idx   (w_data_idx),
        .data_off   (w_data_off),
        .data_wdata (w_data_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_addr  <= '0;
            r_req_write <= 1'b0;
            r_req_wdata <= '0;
        end else if (w_latch) begin
            r_req_addr  <= req_addr[ADDR_W-1:OFF_LSB];
            r_req_write <= req_write;
            r_req_wdata <= req_wdata;
        end
    end

    // Issue and return counters restart on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_cnt  <= '0;
            r_ret_cnt  <= '0;
            r_iss_done <= 1'b0;
        end else if (w_state_nxt != r_state) begin
            r_iss_cnt  <= '0;
            r_ret_cnt  <= '0;
            r_iss_done <= 1'b0;
        end else begin
            if (w_iss_adv) begin
                r_iss_cnt <= r_iss_cnt + 2'd1;
                if (r_iss_cnt == c_LAST_OFF) begin
                    r_iss_done <= 1'b1;
                end
            end
            if (w_ret_adv) begin
                r_ret_cnt <= r_ret_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        stall        = 1'b0;
        done         = 1'b0;
        hit          = 1'b0;
        err          = 1'b0;
        rdata        = '0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w_latch      = 1'b0;
        w_iss_adv    = 1'b0;
        w_ret_adv    = 1'b0;
        w_meta_we    = 1'b0;
        w_meta_dirty = 1'b0;
        w_meta_tag   = '0;
        w_data_we    = 1'b0;
        w_data_idx   = w_rd_idx;
        w_data_off   = '0;
        w_data_wdata = '0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_addr[0]) begin
                        err  = 1'b1;
                        done = 1'b1;
                    end else if (w_hit) begin
                        done = 1'b1;
                        hit  = 1'b1;
                        if (req_write) begin
                            w_meta_we    = 1'b1;
                            w_meta_dirty = 1'b1;
                            w_meta_tag   = w_in_tag;
                            w_data_we    = 1'b1;
                            w_data_off   = w_in_off;
                            w_data_wdata = req_wdata;
                        end else begin
                            rdata = w_rd_line[w_in_off];
                        end
                    end else begin
                        stall       = 1'b1;
                        w_latch     = 1'b1;
                        w_state_nxt = (w_rd_valid && w_rd_dirty) ? ST_EVICT : ST_FILL;
                    end
                end
            end
            ST_EVICT: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = word_addr(w_rd_tag, w_lt_idx, r_iss_cnt);
                mem_wdata = w_rd_line[r_iss_cnt];
                if (mem_ready) begin
                    w_iss_adv = 1'b1;
                    if (r_iss_cnt == c_LAST_OFF) begin
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                stall = 1'b1;
                if (!r_iss_done) begin
                    mem_req  = 1'b1;
                    mem_addr = word_addr(w_lt_tag, w_lt_idx, r_iss_cnt);
                    w_iss_adv = mem_ready;
                end
                if (mem_rvalid) begin
                    w_ret_adv    = 1'b1;
                    w_data_we    = 1'b1;
                    w_data_off   = r_ret_cnt;
                    w_data_wdata = mem_rdata;
                    if (r_ret_cnt == c_LAST_OFF) begin
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                done         = 1'b1;
                w_meta_we    = 1'b1;
                w_meta_dirty = r_req_write;
                w_meta_tag   = w_lt_tag;
                w_state_nxt  = ST_IDLE;
                if (r_req_write) begin
                    w_data_we    = 1'b1;
                    w_data_off   = w_lt_off;
                    w_data_wdata = r_req_wdata;
                end else begin
                    rdata = w_rd_line[w_lt_off];
                end
            end
        endcase
    end

endmodule
`default_nettype wire
